// File: rtl/cnn_pkg.sv
// Definitions shared by the CNN convolution engine and its downstream stages:
// pool FSM state encoding and the memory write word size.
package cnn_pkg;

    localparam int BYTES_TO_WRITE = 4;

    typedef enum logic [2:0] {
        POOL_IDLE  = 3'd0,
        POOL_RUN   = 3'd1,
        POOL_WRITE = 3'd2,
        POOL_DONE  = 3'd3
    } pool_state_e;

endpackage

// File: rtl/cnn_mem_intf.sv
// Shared memory write client interface. A request is held until mem_ack is
// sampled high on a clock edge with mem_req high; that edge completes the write.
interface cnn_mem_intf #(
    parameter int ADDR_WIDTH = 19
) ();
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_start_addr;
    logic [2:0]            mem_size_bytes;
    logic [31:0]           mem_data;
    logic                  last;
    logic                  mem_last_valid;
    logic                  mem_ack;

    modport client_write (
        output mem_req, mem_start_addr, mem_size_bytes, mem_data, last, mem_last_valid,
        input  mem_ack
    );
endinterface

// File: rtl/cnn_max3_s8.sv
// Combinational signed 8-bit maximum of three operands.
module cnn_max3_s8 (
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    input  logic signed [7:0] c,
    output logic signed [7:0] y
);
    logic signed [7:0] ab;

    always_comb begin
        ab = (a > b) ? a : b;
        y  = (ab > c) ? ab : c;
    end
endmodule

// File: rtl/cnn_max_pool.sv
// 2x2 stride-2 signed max-pool over a row-major byte stream, packing pooled
// bytes little-endian into 32-bit memory writes. Input handshake: a byte
// transfers on a rising edge where in_valid && in_ready are both high.
module cnn_max_pool
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH    = 19,
    parameter int MAX_COLS      = 128,
    parameter int LOG2_MAX_COLS = $clog2(MAX_COLS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   sw_pool_addr_z,
    input  logic [LOG2_MAX_COLS:0]  sw_pool_n,
    input  logic [LOG2_MAX_COLS:0]  sw_pool_m,
    input  logic                    sw_pool_go,
    output logic                    pool_sw_busy_ind,
    output logic                    sw_pool_done,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output pool_state_e             dbg_state,
    cnn_mem_intf.client_write       mem_intf_write
);
    localparam int CW = LOG2_MAX_COLS + 1;
    localparam logic [CW-1:0]         ONE       = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES_TO_WRITE);
    localparam logic [2:0]            LAST_LANE = 3'(BYTES_TO_WRITE - 1);
    localparam logic signed [7:0]     S8_MIN    = 8'sh80;

    pool_state_e           state;
    logic                  busy_r, done_r, in_ready_r, mem_req_r, last_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            size_r, byte_cnt;
    logic [31:0]           data_r;
    logic [CW-1:0]         col, row, n_reg, m_reg, n_even, m_even;
    logic signed [7:0]     pair_reg, pool_out, third;
    logic                  pend_final;
    logic [7:0]            line_buf [MAX_COLS/2];

    logic accept, col_last, in_last, keep, pool_en, pool_final, go_write;

    assign n_even     = {n_reg[CW-1:1], 1'b0};
    assign m_even     = {m_reg[CW-1:1], 1'b0};
    assign accept     = in_valid && in_ready_r;
    assign col_last   = (col == n_reg - ONE);
    assign in_last    = col_last && (row == m_reg - ONE);
    // Odd trailing column/row fall outside the even-sized region and are dropped.
    assign keep       = (col < n_even) && (row < m_even);
    assign pool_en    = accept && keep && col[0] && row[0];
    assign pool_final = pool_en && (col == n_even - ONE) && (row == m_even - ONE);
    // The final write waits until the last (possibly discarded) input byte is in.
    assign go_write   = (pool_en && (byte_cnt == LAST_LANE) && !pool_final)
                     || ((pool_final || pend_final) && accept && in_last);

    assign third = row[0] ? $signed(line_buf[col[CW-2:1]]) : S8_MIN;

    cnn_max3_s8 u_max3 (
        .a (pair_reg),
        .b ($signed(in_data)),
        .c (third),
        .y (pool_out)
    );

    always_ff @(posedge clk) begin
        if (accept && keep && col[0] && !row[0])
            line_buf[col[CW-2:1]] <= pool_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= POOL_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            in_ready_r <= 1'b0;
            mem_req_r  <= 1'b0;
            last_r     <= 1'b0;
            addr_r     <= '0;
            size_r     <= '0;
            data_r     <= '0;
            byte_cnt   <= '0;
            col        <= '0;
            row        <= '0;
            n_reg      <= '0;
            m_reg      <= '0;
            pair_reg   <= '0;
            pend_final <= 1'b0;
        end else begin
            case (state)
                POOL_IDLE: begin
                    done_r <= 1'b0;
                    if (sw_pool_go) begin
                        state      <= POOL_RUN;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                        addr_r     <= sw_pool_addr_z;
                        n_reg      <= sw_pool_n;
                        m_reg      <= sw_pool_m;
                        col        <= '0;
                        row        <= '0;
                        byte_cnt   <= '0;
                        data_r     <= '0;
                        last_r     <= 1'b0;
                        pend_final <= 1'b0;
                    end
                end
                POOL_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                        if (!col[0])
                            pair_reg <= $signed(in_data);
                        if (pool_en) begin
                            data_r[{byte_cnt[1:0], 3'b000} +: 8] <= pool_out;
                            byte_cnt <= byte_cnt + 3'd1;
                            size_r   <= byte_cnt + 3'd1;
                        end
                        if (pool_final && !in_last)
                            pend_final <= 1'b1;
                        if (go_write) begin
                            state      <= POOL_WRITE;
                            in_ready_r <= 1'b0;
                            mem_req_r  <= 1'b1;
                            last_r     <= pool_final || pend_final;
                        end
                    end
                end
                POOL_WRITE: begin
                    if (mem_intf_write.mem_ack) begin
                        mem_req_r <= 1'b0;
                        addr_r    <= addr_r + ADDR_STEP;
                        byte_cnt  <= '0;
                        data_r    <= '0;
                        last_r    <= 1'b0;
                        if (last_r) begin
                            state  <= POOL_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            state      <= POOL_RUN;
                            in_ready_r <= 1'b1;
                        end
                    end
                end
                POOL_DONE: begin
                    done_r <= 1'b0;
                    state  <= POOL_IDLE;
                end
                default: state <= POOL_IDLE;
            endcase
        end
    end

    assign pool_sw_busy_ind              = busy_r;
    assign sw_pool_done                  = done_r;
    assign in_ready                      = in_ready_r;
    assign dbg_state                     = state;
    assign mem_intf_write.mem_req        = mem_req_r;
    assign mem_intf_write.mem_start_addr = addr_r;
    assign mem_intf_write.mem_size_bytes = size_r;
    assign mem_intf_write.mem_data       = data_r;
    assign mem_intf_write.last           = last_r;
    assign mem_intf_write.mem_last_valid = last_r;
endmodule

// File: tb/tb_cnn_max_pool.sv
// Directed bench for cnn_max_pool: drives byte frames, answers memory writes
// and compares captured writes against hand-computed pooled words.
module tb_cnn_max_pool;
  import cnn_pkg::*;

  localparam int AW = 19;
  localparam logic [AW-1:0] ADDR_Z = 19'h01000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] sw_pool_addr_z = '0;
  logic [7:0]    sw_pool_n = '0;
  logic [7:0]    sw_pool_m = '0;
  logic          sw_pool_go = 1'b0;
  logic          busy, done, in_ready;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          mem_ack = 1'b0;
  pool_state_e   dbg_state;

  cnn_mem_intf #(.ADDR_WIDTH(AW)) mem_if ();
  assign mem_if.mem_ack = mem_ack;

  cnn_max_pool #(.ADDR_WIDTH(AW), .MAX_COLS(128)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sw_pool_addr_z   (sw_pool_addr_z),
    .sw_pool_n        (sw_pool_n),
    .sw_pool_m        (sw_pool_m),
    .sw_pool_go       (sw_pool_go),
    .pool_sw_busy_ind (busy),
    .sw_pool_done     (done),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .dbg_state        (dbg_state),
    .mem_intf_write   (mem_if)
  );

  int total = 0;
  int bad = 0;

  // stimulus frame and captured writes
  logic [7:0]    frame[$];
  logic [AW-1:0] cap_addr[$];
  logic [2:0]    cap_size[$];
  logic [31:0]   cap_data[$];
  logic          cap_last[$];
  logic          cap_lv[$];

  bit r_timeout;
  bit r_busy_go;
  int r_done, r_overlap, r_drop, r_accepted;

  // driver: go pulse, byte feed, memory responder (ack after ack_delay cycles)
  task automatic run_frame(input int ack_delay, input bit go_again, input int abort_after);
    int idx = 0;
    int cyc = 0;
    int wait_cnt = 0;
    bit vprev = 0, rprev = 0, finished = 0, req_pending = 0;
    cap_addr.delete(); cap_size.delete(); cap_data.delete();
    cap_last.delete(); cap_lv.delete();
    r_done = 0; r_overlap = 0; r_drop = 0; r_busy_go = 0;
    @(negedge clk);
    sw_pool_go = 1'b1;
    in_valid = 1'b0;
    mem_ack = 1'b0;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      sw_pool_go = go_again && (cyc == 3);
      if (vprev && rprev) idx++;
      if (cyc == 1) r_busy_go = busy && in_ready;
      if (mem_if.mem_req && in_ready) r_overlap++;
      if (req_pending && !mem_if.mem_req) r_drop++;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_if.mem_req) begin
        wait_cnt++;
        if (wait_cnt > ack_delay) begin
          cap_addr.push_back(mem_if.mem_start_addr);
          cap_size.push_back(mem_if.mem_size_bytes);
          cap_data.push_back(mem_if.mem_data);
          cap_last.push_back(mem_if.last);
          cap_lv.push_back(mem_if.mem_last_valid);
          mem_ack = 1'b1;
        end
      end
      req_pending = mem_if.mem_req && !mem_ack;
      if (done) begin
        r_done++;
        finished = 1;
      end
      if (abort_after >= 0 && idx >= abort_after) finished = 1;
      in_valid = !finished && (idx < frame.size());
      in_data = in_valid ? frame[idx] : 8'h00;
      vprev = in_valid;
      rprev = in_ready;
    end
    in_valid = 1'b0;
    sw_pool_go = 1'b0;
    r_accepted = idx;
    r_timeout = !finished;
  endtask

  task automatic setup(input int n, input int m);
    sw_pool_addr_z = ADDR_Z;
    sw_pool_n = 8'(n);
    sw_pool_m = 8'(m);
    frame.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, in_ready, mem_if.mem_req, mem_if.last, mem_if.mem_last_valid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {busy, done, in_ready, mem_if.mem_req, mem_if.last, mem_if.mem_last_valid});
    end
    total++;
    if (mem_if.mem_start_addr !== '0 || mem_if.mem_size_bytes !== 3'd0 || mem_if.mem_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus addr=%h size=%0d data=%h want 0", mem_if.mem_start_addr,
               mem_if.mem_size_bytes, mem_if.mem_data);
    end
    total++;
    if (dbg_state !== POOL_IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, POOL_IDLE);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    setup(4, 4);
    for (int i = 0; i < 16; i++) frame.push_back(8'(i));
    run_frame(0, 1'b0, -1);
    total++;
    if (r_timeout || r_done != 1) begin
      bad++;
      $display("FAIL basic_done timeout=%0d done=%0d want 0/1", r_timeout, r_done);
    end
    total++;
    if (!r_busy_go) begin
      bad++;
      $display("FAIL basic_go_latency busy&ready=%0d want=1", r_busy_go);
    end
    total++;
    if (cap_data.size() != 1) begin
      bad++;
      $display("FAIL basic_writes got=%0d want=1", cap_data.size());
    end else begin
      total++;
      if (cap_addr[0] !== ADDR_Z || cap_size[0] !== 3'd4 || cap_data[0] !== 32'h0F0D0705
          || cap_last[0] !== 1'b1 || cap_lv[0] !== 1'b1) begin
        bad++;
        $display("FAIL basic_word addr=%h size=%0d data=%h last=%b lv=%b want %h/4/0f0d0705/1/1",
                 cap_addr[0], cap_size[0], cap_data[0], cap_last[0], cap_lv[0], ADDR_Z);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== POOL_IDLE) begin
      bad++;
      $display("FAIL basic_done_pulse done=%b busy=%b state=%0d want 0/0/0", done, busy, dbg_state);
    end
  endtask

  task automatic test_signed();
    setup(4, 4);
    for (int i = 0; i < 16; i++) frame.push_back((i == 10) ? 8'h01 : 8'h80);
    run_frame(0, 1'b0, -1);
    total++;
    if (r_timeout || cap_data.size() != 1) begin
      bad++;
      $display("FAIL signed_writes timeout=%0d writes=%0d want 0/1", r_timeout, cap_data.size());
    end else begin
      total++;
      if (cap_data[0] !== 32'h01808080 || cap_size[0] !== 3'd4) begin
        bad++;
        $display("FAIL signed_word data=%h size=%0d want 01808080/4", cap_data[0], cap_size[0]);
      end
    end
  endtask

  task automatic test_multi_word();
    logic [31:0] exp_d[3] = '{32'h0, 32'h0, 32'h00000009};
    logic [2:0]  exp_s[3] = '{3'd4, 3'd4, 3'd1};
    setup(6, 6);
    for (int i = 0; i < 36; i++) frame.push_back((i == 35) ? 8'h09 : 8'h00);
    run_frame(0, 1'b0, -1);
    total++;
    if (r_timeout || cap_data.size() != 3) begin
      bad++;
      $display("FAIL multi_writes timeout=%0d writes=%0d want 0/3", r_timeout, cap_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cap_addr[i] !== ADDR_Z + AW'(4 * i) || cap_size[i] !== exp_s[i] || cap_data[i] !== exp_d[i]
            || cap_last[i] !== (i == 2) || cap_lv[i] !== (i == 2)) begin
          bad++;
          $display("FAIL multi_word%0d addr=%h size=%0d data=%h last=%b lv=%b want %h/%0d/%h/%0d",
                   i, cap_addr[i], cap_size[i], cap_data[i], cap_last[i], cap_lv[i],
                   ADDR_Z + AW'(4 * i), exp_s[i], exp_d[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_odd_dims();
    setup(5, 5);
    for (int i = 0; i < 25; i++) frame.push_back(8'(i));
    run_frame(0, 1'b0, -1);
    total++;
    if (r_timeout || r_accepted != 25 || cap_data.size() != 1) begin
      bad++;
      $display("FAIL odd_writes timeout=%0d accepted=%0d writes=%0d want 0/25/1",
               r_timeout, r_accepted, cap_data.size());
    end else begin
      total++;
      if (cap_data[0] !== 32'h12100806 || cap_size[0] !== 3'd4 || cap_lv[0] !== 1'b1) begin
        bad++;
        $display("FAIL odd_word data=%h size=%0d lv=%b want 12100806/4/1",
                 cap_data[0], cap_size[0], cap_lv[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[3] = '{32'h01F9F7F5, 32'h0F0D0503, 32'h00000011};
    setup(6, 6);
    for (int i = 0; i < 36; i++) frame.push_back(8'(i - 18));
    run_frame(7, 1'b1, -1);
    total++;
    if (r_timeout || r_done != 1 || r_accepted != 36) begin
      bad++;
      $display("FAIL stall_done timeout=%0d done=%0d accepted=%0d want 0/1/36",
               r_timeout, r_done, r_accepted);
    end
    total++;
    if (r_overlap != 0 || r_drop != 0) begin
      bad++;
      $display("FAIL stall_handshake ready_during_req=%0d req_drops=%0d want 0/0", r_overlap, r_drop);
    end
    total++;
    if (cap_data.size() != 3) begin
      bad++;
      $display("FAIL stall_writes got=%0d want=3", cap_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cap_data[i] !== exp_d[i] || cap_addr[i] !== ADDR_Z + AW'(4 * i)) begin
          bad++;
          $display("FAIL stall_word%0d data=%h addr=%h want %h/%h", i, cap_data[i], cap_addr[i],
                   exp_d[i], ADDR_Z + AW'(4 * i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    setup(4, 4);
    for (int i = 0; i < 16; i++) frame.push_back(8'(i));
    run_frame(0, 1'b0, 14);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, in_ready, mem_if.mem_req, mem_if.last} !== 5'b0
        || mem_if.mem_start_addr !== '0 || mem_if.mem_data !== 32'h0 || dbg_state !== POOL_IDLE) begin
      bad++;
      $display("FAIL midreset_outputs flags=%b addr=%h data=%h state=%0d want all 0",
               {busy, done, in_ready, mem_if.mem_req, mem_if.last}, mem_if.mem_start_addr,
               mem_if.mem_data, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b0, -1);
    total++;
    if (r_timeout || cap_data.size() != 1) begin
      bad++;
      $display("FAIL midreset_writes timeout=%0d writes=%0d want 0/1", r_timeout, cap_data.size());
    end else begin
      total++;
      if (cap_data[0] !== 32'h0F0D0705 || cap_addr[0] !== ADDR_Z || cap_last[0] !== 1'b1) begin
        bad++;
        $display("FAIL midreset_word data=%h addr=%h last=%b want 0f0d0705/%h/1",
                 cap_data[0], cap_addr[0], cap_last[0], ADDR_Z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_multi_word();
    test_odd_dims();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
